// File: rtl/pll_lock_if.sv
// Control/status bundle between the PLL lock sequencer and the system around it.
// The slave side is the sequencer; the master side drives lock/requests and reads status.
`timescale 1ns/1ps
interface pll_lock_if #(
    parameter int CNT_W = 8
);
    logic             pll_locked;
    logic             force_relock;
    logic             clear_counts;
    logic             pll_rst;
    logic             sys_reset;
    logic             ready;
    logic             fail;
    logic [CNT_W-1:0] retry_count;
    logic [CNT_W-1:0] loss_count;

    modport master (
        output pll_locked, force_relock, clear_counts,
        input  pll_rst, sys_reset, ready, fail, retry_count, loss_count
    );

    modport slave (
        input  pll_locked, force_relock, clear_counts,
        output pll_rst, sys_reset, ready, fail, retry_count, loss_count
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock and only then
// releases the system reset; retries on timeout, re-sequences on lock loss, counts events.
`timescale 1ns/1ps
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic      clk,
    input  logic      rst,
    pll_lock_if.slave bus
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int MAX_T = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int TMR_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_PLL_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] retry_q, retry_d, retry_inc;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             lk_meta, lk_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // pll_locked is asynchronous to clk: two flops before anything looks at it
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= bus.pll_locked;
            lk_s    <= lk_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_PLL_RESET;
            timer_q <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        loss_d    = loss_q;
        retry_inc = sat_inc(retry_q);

        if (bus.force_relock) begin
            state_d = S_PLL_RESET;
            retry_d = '0;
        end else begin
            case (state_q)
                S_PLL_RESET: begin
                    if (timer_q == RST_LAST)
                        state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lk_s) begin
                        state_d = S_STABLE;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        state_d = (int'(retry_inc) >= MAX_RETRIES) ? S_FAIL : S_PLL_RESET;
                    end
                end
                S_STABLE: begin
                    if (!lk_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        retry_d = '0;
                    end
                end
                S_RUN: begin
                    if (!lk_s) begin
                        state_d = S_PLL_RESET;
                        loss_d  = sat_inc(loss_q);
                    end
                end
                S_FAIL:  state_d = S_FAIL;
                default: state_d = S_PLL_RESET;
            endcase
        end

        // a clear request beats a simultaneous loss increment
        if (bus.clear_counts)
            loss_d = '0;

        // RUN and FAIL have no timed exit, so the timer parks at zero there
        if (bus.force_relock || (state_d != state_q) ||
            (state_q == S_RUN) || (state_q == S_FAIL))
            timer_d = '0;
        else
            timer_d = timer_q + 1'b1;
    end

    always_comb begin
        bus.pll_rst   = 1'b1;
        bus.sys_reset = 1'b1;
        bus.ready     = 1'b0;
        bus.fail      = 1'b0;
        case (state_q)
            S_WAIT_LOCK, S_STABLE: bus.pll_rst = 1'b0;
            S_RUN: begin
                bus.pll_rst   = 1'b0;
                bus.sys_reset = 1'b0;
                bus.ready     = 1'b1;
            end
            S_FAIL:  bus.fail = 1'b1;
            default: ;
        endcase
    end

    assign bus.retry_count = retry_q;
    assign bus.loss_count  = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus random lock/request traffic,
// every cycle scored against a countdown-based reference model through a queue.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;
    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 3;
    localparam int CNT_W         = 4;
    localparam int CNT_MAX       = (1 << CNT_W) - 1;
    localparam int OW            = 4 + 2 * CNT_W;

    localparam int P_RESET  = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAIL   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pll_lock_if #(.CNT_W(CNT_W)) bus ();

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: phase plus cycles left in it, lock seen through a 2-deep history
    int m_phase, m_left, m_retry, m_loss;
    bit m_hist[$];
    logic [OW-1:0] exp_q[$];

    function automatic int phase_len(input int p);
        case (p)
            P_RESET:  return RST_CYCLES;
            P_WAIT:   return LOCK_TIMEOUT;
            P_STABLE: return STABLE_CYCLES;
            default:  return 0;
        endcase
    endfunction

    function automatic logic [OW-1:0] model_outputs();
        return {(m_phase == P_RESET) || (m_phase == P_FAIL), m_phase != P_RUN,
                m_phase == P_RUN, m_phase == P_FAIL,
                CNT_W'(m_retry), CNT_W'(m_loss)};
    endfunction

    task automatic model_step();
        bit lk_now;
        bit restart;
        int nxt;
        if (rst) begin
            m_phase = P_RESET;
            m_left  = RST_CYCLES;
            m_retry = 0;
            m_loss  = 0;
            m_hist.delete();
            m_hist.push_back(1'b0);
            m_hist.push_back(1'b0);
        end else begin
            lk_now = m_hist.pop_front();
            m_hist.push_back(bus.pll_locked);
            restart = 1'b0;
            nxt     = m_phase;
            if (bus.force_relock) begin
                nxt     = P_RESET;
                restart = 1'b1;
                m_retry = 0;
            end else begin
                m_left = m_left - 1;
                case (m_phase)
                    P_RESET: if (m_left == 0) begin nxt = P_WAIT; restart = 1'b1; end
                    P_WAIT: begin
                        if (lk_now) begin
                            nxt = P_STABLE; restart = 1'b1;
                        end else if (m_left == 0) begin
                            m_retry = (m_retry < CNT_MAX) ? m_retry + 1 : CNT_MAX;
                            nxt     = (m_retry >= MAX_RETRIES) ? P_FAIL : P_RESET;
                            restart = 1'b1;
                        end
                    end
                    P_STABLE: begin
                        if (!lk_now) begin
                            nxt = P_WAIT; restart = 1'b1;
                        end else if (m_left == 0) begin
                            nxt = P_RUN; restart = 1'b1; m_retry = 0;
                        end
                    end
                    P_RUN: begin
                        if (!lk_now) begin
                            m_loss  = (m_loss < CNT_MAX) ? m_loss + 1 : CNT_MAX;
                            nxt     = P_RESET;
                            restart = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (bus.clear_counts) m_loss = 0;
            if (restart) begin
                m_phase = nxt;
                m_left  = phase_len(nxt);
            end
        end
        exp_q.push_back(model_outputs());
    endtask

    initial begin : model_proc
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin : monitor_proc
        logic [OW-1:0] e;
        logic [OW-1:0] a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.pll_rst, bus.sys_reset, bus.ready, bus.fail,
                     bus.retry_count, bus.loss_count};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_outputs t=%0t: got {pll_rst,sys_reset,ready,fail,retry,loss}=%b_%b_%b_%b_%0d_%0d, expected %b_%b_%b_%b_%0d_%0d",
                             $time, a[OW-1], a[OW-2], a[OW-3], a[OW-4], a[2*CNT_W-1:CNT_W], a[CNT_W-1:0],
                             e[OW-1], e[OW-2], e[OW-3], e[OW-4], e[2*CNT_W-1:CNT_W], e[CNT_W-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (!bus.ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(name, bus.ready, 1);
    endtask

    task automatic measure_pll_rst(input string name);
        int k;
        k = 0;
        while (bus.pll_rst && k < 50) begin
            k++;
            @(negedge clk);
        end
        check(name, k, RST_CYCLES);
    endtask

    task automatic lose_lock();
        bus.pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        bus.pll_locked = 1'b1;
    endtask

    initial begin : watchdog
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : stimulus
        int k;
        int hold;
        bus.pll_locked   = 1'b0;
        bus.force_relock = 1'b0;
        bus.clear_counts = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        check("reset pll_rst", bus.pll_rst, 1);
        check("reset sys_reset", bus.sys_reset, 1);
        check("reset ready", bus.ready, 0);
        check("reset fail", bus.fail, 0);
        check("reset retry_count", bus.retry_count, 0);
        check("reset loss_count", bus.loss_count, 0);

        // clean lock
        rst = 1'b0;
        measure_pll_rst("pll_rst width after reset");
        repeat (3) @(negedge clk);
        bus.pll_locked = 1'b1;
        @(negedge clk);
        k = 0;
        while (bus.sys_reset && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("edges from lock sample to sys_reset fall", k, STABLE_CYCLES + 2);
        check("clean lock ready", bus.ready, 1);
        check("clean lock retry_count", bus.retry_count, 0);

        // timeout retries to FAIL
        rst = 1'b1;
        bus.pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        k = 0;
        while (!bus.fail && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("cycles to fail", k, MAX_RETRIES * (RST_CYCLES + LOCK_TIMEOUT));
        check("fail retry_count", bus.retry_count, MAX_RETRIES);
        repeat (10) @(negedge clk);
        check("fail held", bus.fail, 1);
        check("fail pll_rst", bus.pll_rst, 1);

        // force_relock out of FAIL, then a one-cycle glitch at STABLE timer 5
        bus.force_relock = 1'b1;
        bus.pll_locked   = 1'b1;
        @(negedge clk);
        bus.force_relock = 1'b0;
        check("force pll_rst", bus.pll_rst, 1);
        check("force clears fail", bus.fail, 0);
        check("force clears retry_count", bus.retry_count, 0);
        k = 0;
        while (bus.sys_reset && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 8) bus.pll_locked = 1'b0;
            else if (k == 9) bus.pll_locked = 1'b1;
        end
        check("glitch delays release to edge", k, 20);
        check("glitch retry_count", bus.retry_count, 0);
        check("glitch loss_count", bus.loss_count, 0);

        // loss in RUN
        bus.pll_locked = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.sys_reset && k < 10);
        check("loss to sys_reset edges", k, 3);
        check("loss pll_rst", bus.pll_rst, 1);
        check("loss_count after one loss", bus.loss_count, 1);
        bus.pll_locked = 1'b1;
        wait_ready("resequence after loss");

        // saturation: 16 more losses
        for (int i = 0; i < 16; i++) begin
            lose_lock();
            wait_ready("ready after repeated loss");
        end
        check("loss_count saturated", bus.loss_count, CNT_MAX);

        // clear_counts on the same edge as a loss
        bus.pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        bus.clear_counts = 1'b1;
        @(negedge clk);
        bus.clear_counts = 1'b0;
        check("clear beats loss", bus.loss_count, 0);
        check("loss still taken", bus.sys_reset, 1);
        bus.pll_locked = 1'b1;
        wait_ready("ready after clear");

        // rst in STABLE at timer 4
        lose_lock();
        wait_ready("ready before mid-stable reset");
        bus.force_relock = 1'b1;
        @(negedge clk);
        bus.force_relock = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-reset loss_count", bus.loss_count, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid reset pll_rst", bus.pll_rst, 1);
        check("mid reset sys_reset", bus.sys_reset, 1);
        check("mid reset ready", bus.ready, 0);
        check("mid reset fail", bus.fail, 0);
        check("mid reset loss_count", bus.loss_count, 0);
        rst = 1'b0;
        measure_pll_rst("pll_rst width after mid reset");
        wait_ready("ready after mid reset");

        // random traffic, scored by the model every cycle
        for (int i = 0; i < 150; i++) begin
            bus.pll_locked = 1'($urandom_range(0, 1));
            hold = bus.pll_locked ? $urandom_range(1, 40) : $urandom_range(1, 30);
            repeat (hold) begin
                bus.force_relock = ($urandom_range(0, 40) == 0);
                bus.clear_counts = ($urandom_range(0, 30) == 0);
                rst = ($urandom_range(0, 150) == 0);
                @(negedge clk);
            end
        end
        bus.force_relock = 1'b0;
        bus.clear_counts = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Reset-and-lock controller on the `refclk` (50 MHz) side of the system PLL. Drives the PLL's `rst`, watches its asynchronous `locked` output, and releases the system reset only after lock has been stable for a programmed interval. Retries on lock timeout, re-sequences on loss of lock, and reports fault status and event counts to the HPS-visible status logic.

## Interface
Parameters:
- `RST_CYCLES`, 16: width of each `pll_rst` pulse, in cycles (>=1).
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: cycles `locked` must stay high before `sys_reset` is released.
- `MAX_RETRIES`, 4: number of consecutive timeouts that leads to FAIL (>=1).
- `CNT_W`, 8: width of the event counters.

Ports:
- `clk` in 1: PLL reference clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL `locked`; asynchronous to `clk`.
- `force_relock` in 1: single-cycle request to restart the full sequence.
- `clear_counts` in 1: single-cycle request to clear `loss_count`.
- `pll_rst` out 1: reset to the PLL.
- `sys_reset` out 1: active-high reset for logic clocked by the PLL output.
- `ready` out 1: high in RUN.
- `fail` out 1: high in FAIL.
- `retry_count` out CNT_W: timeouts since the last successful lock.
- `loss_count` out CNT_W: lock losses seen while in RUN.

## Operation
- `pll_locked` passes through a 2-FF synchronizer. Only the second stage, `lk_s`, is used; both stages reset to 0.
- One timer, wide enough for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES). It clears on every state change.
- Outputs are Moore, decoded from the state register only:
  - PLL_RESET: `pll_rst`=1, `sys_reset`=1.
  - WAIT_LOCK: `pll_rst`=0, `sys_reset`=1.
  - STABLE: `pll_rst`=0, `sys_reset`=1.
  - RUN: `pll_rst`=0, `sys_reset`=0, `ready`=1.
  - FAIL: `pll_rst`=1, `sys_reset`=1, `fail`=1.
- State transitions:
  - PLL_RESET: when timer = RST_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: if `lk_s`=1, go to STABLE. Otherwise, when timer = LOCK_TIMEOUT-1, increment `retry_count`. If the new value >= MAX_RETRIES go to FAIL, else go to PLL_RESET.
  - STABLE: if `lk_s`=0, go to WAIT_LOCK; no count changes. Otherwise, when timer = STABLE_CYCLES-1, go to RUN and clear `retry_count`.
  - RUN: if `lk_s`=0, go to PLL_RESET and increment `loss_count`.
  - FAIL: held until `rst` or `force_relock`.
- `force_relock` applies in any state. It takes priority over all other transitions: next state is PLL_RESET, timer and `retry_count` clear, `loss_count` is unchanged.
- Both counters saturate at 2^CNT_W-1.
- If `clear_counts` and a `loss_count` increment occur in the same cycle, clear wins and the result is 0.

## Timing
- Reset values: state PLL_RESET, timer 0, sync stages 0, `pll_rst`=1, `sys_reset`=1, `ready`=0, `fail`=0, both counts 0.
- `rst` asserted mid-sequence returns the block to the reset values on the next edge, whatever the current state.
- After `rst` deasserts, `pll_rst` stays high for exactly RST_CYCLES cycles.
- `pll_locked` high before edge n:
  - `lk_s`=1 after edge n+1.
  - STABLE after edge n+2.
  - RUN, with `sys_reset` falling, after edge n+2+STABLE_CYCLES.
- `pll_locked` low before edge m while in RUN:
  - `sys_reset`=1 and `pll_rst`=1 after edge m+2.
  - `loss_count` is updated at the same edge.
- A timeout retry costs LOCK_TIMEOUT+RST_CYCLES cycles from WAIT_LOCK entry to the next WAIT_LOCK entry.
- A `lk_s` glitch shorter than STABLE_CYCLES never releases `sys_reset`.
- `force_relock` sampled at edge k: `pll_rst`=1 after edge k.

## Test plan
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3, CNT_W=4.
- Clean lock: release `rst`, raise `pll_locked` 3 cycles after `pll_rst` falls -> `pll_rst` high exactly 4 cycles, `sys_reset` falls 10 cycles after `pll_locked` rises, `ready`=1, `retry_count`=0.
- Timeout/fail: hold `pll_locked`=0 -> three `pll_rst` pulses of 4 cycles each, 20 cycles apart -> `fail`=1 with `retry_count`=3 at cycle 3*(4+20). Then `force_relock` -> `pll_rst` pulse, `retry_count`=0.
- Glitch: in STABLE, drop `pll_locked` for 1 cycle at timer 5 -> back to WAIT_LOCK, then full 8-cycle STABLE. `sys_reset` is never low early and no counter changes.
- Loss in RUN: drop `pll_locked` for 3 cycles while in RUN -> `sys_reset`=1 2 cycles later, `loss_count`=1, then a full re-sequence back to RUN.
- Saturation/priority:
  - 17 losses -> `loss_count`=15.
  - `clear_counts` on the same cycle as a loss -> `loss_count`=0.
- Reset mid-STABLE: assert `rst` at timer 4 -> all outputs at reset values on the next edge, and the sequence restarts from PLL_RESET.
